// File: rtl/dac714_serializer_if.sv
// Parallel-request / serial-DAC bus between a word source and the DAC714 serializer.
interface dac714_serializer_if #(
   parameter int unsigned DAC_WIDTH = 16
);
   logic                        dac_strobe;
   logic signed [DAC_WIDTH-1:0] dac_out;
   logic                        sdi;
   logic                        sclk;
   logic                        nA0;
   logic                        nA1;
   logic                        busy;
   logic [7:0]                  overrun_cnt;

   modport master (
      output dac_strobe, dac_out,
      input  sdi, sclk, nA0, nA1, busy, overrun_cnt
   );

   modport slave (
      input  dac_strobe, dac_out,
      output sdi, sclk, nA0, nA1, busy, overrun_cnt
   );
endinterface

// File: rtl/dac714_serializer.sv
// Serializes a two's-complement word MSB first to a DAC714, then pulses nA0/nA1 to latch it.
// CLK_DIV and LATCH_CYCLES are legal in 1..255.
module dac714_serializer #(
   parameter int unsigned DAC_WIDTH    = 16,
   parameter int unsigned CLK_DIV      = 4,
   parameter int unsigned LATCH_CYCLES = 2
) (
   input logic                clk,
   input logic                nReset,
   dac714_serializer_if.slave bus
);
   localparam int unsigned BIT_W = (DAC_WIDTH > 1) ? $clog2(DAC_WIDTH) : 1;
   localparam int unsigned CNT_W = 8;
   localparam logic [BIT_W-1:0] BIT_RELOAD   = BIT_W'(DAC_WIDTH - 1);
   localparam logic [CNT_W-1:0] DIV_RELOAD   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] LATCH_RELOAD = CNT_W'(LATCH_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH, GAP} state_t;

   state_t               state;
   logic                 strb_d;
   logic                 req_c;
   logic [DAC_WIDTH-1:0] shreg;
   logic [BIT_W-1:0]     bit_cnt;
   logic [CNT_W-1:0]     div_cnt;
   logic [CNT_W-1:0]     latch_cnt;
   logic                 sclk_q;
   logic                 na_q;
   logic                 busy_q;
   logic [7:0]           ovr_q;

   // strb_d resets high so a strobe already asserted at reset release is not a request
   assign req_c = bus.dac_strobe & ~strb_d;

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) strb_d <= 1'b1;
      else         strb_d <= bus.dac_strobe;
   end

   // Transfer sequencer: shift out the word, pulse the latch, one gap cycle
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state     <= IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         div_cnt   <= '0;
         latch_cnt <= '0;
         sclk_q    <= 1'b0;
         na_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_c) begin
                  shreg   <= bus.dac_out;
                  bit_cnt <= BIT_RELOAD;
                  div_cnt <= DIV_RELOAD;
                  sclk_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (div_cnt == '0) begin
                  div_cnt <= DIV_RELOAD;
                  if (!sclk_q) begin
                     sclk_q <= 1'b1;
                  end else if (bit_cnt == '0) begin
                     // last falling edge: no shift, go latch
                     sclk_q    <= 1'b0;
                     na_q      <= 1'b0;
                     latch_cnt <= LATCH_RELOAD;
                     state     <= LATCH;
                  end else begin
                     sclk_q  <= 1'b0;
                     shreg   <= shreg << 1;
                     bit_cnt <= bit_cnt - BIT_W'(1);
                  end
               end else begin
                  div_cnt <= div_cnt - CNT_W'(1);
               end
            end
            LATCH: begin
               if (latch_cnt == '0) begin
                  na_q  <= 1'b1;
                  state <= GAP;
               end else begin
                  latch_cnt <= latch_cnt - CNT_W'(1);
               end
            end
            GAP: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Requests arriving outside IDLE (GAP included) are dropped and counted
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset)                                         ovr_q <= '0;
      else if (req_c && (state != IDLE) && (ovr_q != 8'hFF)) ovr_q <= ovr_q + 8'd1;
   end

   assign bus.sdi         = shreg[DAC_WIDTH-1];
   assign bus.sclk        = sclk_q;
   assign bus.nA0         = na_q;
   assign bus.nA1         = na_q;
   assign bus.busy        = busy_q;
   assign bus.overrun_cnt = ovr_q;
endmodule

// File: tb/tb_dac714_serializer.sv
// Directed bench for dac714_serializer: default instance (a) and CLK_DIV=1 instance (b),
// with a word scoreboard fed at strobe time and drained at each latch pulse.
module tb_dac714_serializer;
   logic clk = 1'b0;
   logic nReset;
   always #5 clk = ~clk;

   dac714_serializer_if #(.DAC_WIDTH(16)) if_a ();
   dac714_serializer_if #(.DAC_WIDTH(16)) if_b ();

   dac714_serializer #(.DAC_WIDTH(16), .CLK_DIV(4), .LATCH_CYCLES(2)) dut_a (
      .clk(clk), .nReset(nReset), .bus(if_a));
   dac714_serializer #(.DAC_WIDTH(16), .CLK_DIV(1), .LATCH_CYCLES(2)) dut_b (
      .clk(clk), .nReset(nReset), .bus(if_b));

   int errors = 0;
   int checks = 0;
   logic [15:0] exp_q[$];

   logic [1:0] busy_s, sclk_s, sdi_s, na0_s, na1_s;
   assign busy_s = {if_b.busy, if_a.busy};
   assign sclk_s = {if_b.sclk, if_a.sclk};
   assign sdi_s  = {if_b.sdi,  if_a.sdi};
   assign na0_s  = {if_b.nA0,  if_a.nA0};
   assign na1_s  = {if_b.nA1,  if_a.nA1};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int cd_of(input int k);
      return (k == 0) ? 4 : 1;
   endfunction

   // Bus monitor: rebuilds each word from sclk rises and checks timing
   int          busy_len[2];
   int          rise_gap[2];
   int          na_len[2];
   int          nbits[2];
   int          latch_pulses[2];
   logic [15:0] word[2];
   logic [1:0]  prev_sclk = '0, prev_na = '1, prev_busy = '0;

   initial begin
      for (int k = 0; k < 2; k++) begin
         busy_len[k] = 0; rise_gap[k] = 0; na_len[k] = 0; nbits[k] = 0;
         latch_pulses[k] = 0; word[k] = '0;
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!nReset) begin
            busy_len[k] = 0; rise_gap[k] = 0; na_len[k] = 0; nbits[k] = 0;
         end else begin
            if (busy_s[k]) busy_len[k]++;
            rise_gap[k]++;
            if (sclk_s[k] && !prev_sclk[k]) begin
               if (nbits[k] == 0) check("first_rise_latency", busy_len[k], cd_of(k) + 1);
               else               check("bit_period", rise_gap[k], 2 * cd_of(k));
               rise_gap[k] = 0;
               word[k] = {word[k][14:0], sdi_s[k]};
               nbits[k]++;
            end
            if (!na0_s[k]) na_len[k]++;
            if (!na0_s[k] && prev_na[k]) begin
               logic [15:0] e;
               latch_pulses[k]++;
               check("latch_na1", na1_s[k], 0);
               check("sclk_in_latch", sclk_s[k], 0);
               check("latch_bitcount", nbits[k], 16);
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $error("FAIL scoreboard_empty: observed word=0x%0h expected none queued", word[k]);
               end else begin
                  e = exp_q.pop_front();
                  check("word", word[k], e);
               end
            end
            if (na0_s[k] && !prev_na[k]) begin
               check("latch_len", na_len[k], 2);
               check("gap_busy", busy_s[k], 1);
               na_len[k] = 0;
            end
            if (!busy_s[k] && prev_busy[k]) begin
               check("busy_len", busy_len[k], 32 * cd_of(k) + 3);
               busy_len[k] = 0;
               nbits[k] = 0;
            end
         end
      end
      prev_sclk = sclk_s;
      prev_na   = na0_s;
      prev_busy = busy_s;
   end

   task automatic set_strb(input int k, input logic s, input logic [15:0] w);
      if (k == 0) begin if_a.dac_out = w; if_a.dac_strobe = s; end
      else        begin if_b.dac_out = w; if_b.dac_strobe = s; end
   endtask

   task automatic wait_idle(input int k, input int bound);
      int n = 0;
      while (busy_s[k] && n < bound) begin @(negedge clk); n++; end
      check("idle_timeout", busy_s[k], 0);
   endtask

   task automatic wait_na(input logic lvl, input int bound, input string tag);
      int n = 0;
      while (na0_s[0] !== lvl && n < bound) begin @(negedge clk); n++; end
      check(tag, na0_s[0], lvl);
   endtask

   initial begin
      int busy_seen;
      int dropped;
      int iters;
      int exp_ovr;
      logic [15:0] w;

      nReset = 1'b0;
      set_strb(0, 1'b0, 16'h0000);
      set_strb(1, 1'b0, 16'h0000);
      repeat (3) @(negedge clk);
      check("rst_sdi", if_a.sdi, 0);
      check("rst_sclk", if_a.sclk, 0);
      check("rst_nA0", if_a.nA0, 1);
      check("rst_nA1", if_a.nA1, 1);
      check("rst_busy", if_a.busy, 0);
      check("rst_overrun", if_a.overrun_cnt, 0);
      check("rst_busy_b", if_b.busy, 0);
      nReset = 1'b1;
      repeat (2) @(negedge clk);

      // 0x8001 on default instance; dac_out changed mid-transfer
      set_strb(0, 1'b1, 16'h8001); exp_q.push_back(16'h8001);
      @(negedge clk);
      check("busy_latency", if_a.busy, 1);
      if_a.dac_out = 16'h7FFE;
      wait_idle(0, 200);
      check("latch_count_t1", latch_pulses[0], 1);
      check("overrun_t1", if_a.overrun_cnt, 0);
      check("sclk_idle", if_a.sclk, 0);
      set_strb(0, 1'b0, 16'h7FFE);

      // 0x5555 with CLK_DIV=1
      @(negedge clk);
      set_strb(1, 1'b1, 16'h5555); exp_q.push_back(16'h5555);
      @(negedge clk);
      check("busy_latency_b", if_b.busy, 1);
      wait_idle(1, 100);
      check("latch_count_b", latch_pulses[1], 1);
      set_strb(1, 1'b0, 16'h5555);

      // Second edge 40 cycles into a transfer is dropped
      @(negedge clk);
      set_strb(0, 1'b1, 16'h1234); exp_q.push_back(16'h1234);
      repeat (20) @(negedge clk);
      set_strb(0, 1'b0, 16'h1234);
      repeat (20) @(negedge clk);
      set_strb(0, 1'b1, 16'hBEEF);
      wait_idle(0, 200);
      check("overrun_one", if_a.overrun_cnt, 1);
      check("latch_count_t3", latch_pulses[0], 2);

      // Back-to-back: edge in the cycle busy falls
      set_strb(0, 1'b0, 16'hBEEF);
      @(negedge clk);
      set_strb(0, 1'b1, 16'h0F0F); exp_q.push_back(16'h0F0F);
      @(negedge clk);
      set_strb(0, 1'b0, 16'h0F0F);
      wait_idle(0, 200);
      set_strb(0, 1'b1, 16'hA5C3); exp_q.push_back(16'hA5C3);
      @(negedge clk);
      check("back_to_back_busy", if_a.busy, 1);
      check("overrun_b2b", if_a.overrun_cnt, 1);
      set_strb(0, 1'b0, 16'hA5C3);

      // Edge in the GAP cycle is dropped
      wait_na(1'b0, 200, "latch_start_timeout");
      wait_na(1'b1, 10, "latch_end_timeout");
      check("in_gap_busy", if_a.busy, 1);
      set_strb(0, 1'b1, 16'hFFFF);
      @(negedge clk);
      check("gap_req_busy", if_a.busy, 0);
      check("gap_req_overrun", if_a.overrun_cnt, 2);
      @(negedge clk);
      check("gap_req_no_start", if_a.busy, 0);
      check("latch_count_t5", latch_pulses[0], 4);

      // Reset 60 cycles into a transfer; strobe held high across release
      set_strb(0, 1'b0, 16'hFFFF);
      @(negedge clk);
      set_strb(0, 1'b1, 16'h7777);
      repeat (60) @(negedge clk);
      #2 nReset = 1'b0;
      #1;
      check("mid_rst_sdi", if_a.sdi, 0);
      check("mid_rst_sclk", if_a.sclk, 0);
      check("mid_rst_nA0", if_a.nA0, 1);
      check("mid_rst_nA1", if_a.nA1, 1);
      check("mid_rst_busy", if_a.busy, 0);
      check("mid_rst_overrun", if_a.overrun_cnt, 0);
      @(negedge clk);
      @(negedge clk);
      nReset = 1'b1;
      busy_seen = 0;
      repeat (200) begin @(negedge clk); if (busy_s[0]) busy_seen++; end
      check("no_start_after_rst", busy_seen, 0);
      check("latch_count_rst", latch_pulses[0], 4);

      // 300 dropped edges saturate the overrun counter
      set_strb(0, 1'b0, 16'h0000);
      dropped = 0; iters = 0; exp_ovr = 0;
      while (dropped < 300 && iters < 2000) begin
         @(negedge clk);
         if_a.dac_strobe = 1'b0;
         @(negedge clk);
         w = 16'($urandom);
         if (busy_s[0]) begin
            dropped++;
            if (exp_ovr < 255) exp_ovr++;
         end else begin
            exp_q.push_back(w);
         end
         set_strb(0, 1'b1, w);
         iters++;
      end
      check("saturate_loop_bound", dropped, 300);
      set_strb(0, 1'b0, 16'h0000);
      @(negedge clk);
      wait_idle(0, 300);
      check("overrun_model", if_a.overrun_cnt, exp_ovr);
      check("overrun_saturated", if_a.overrun_cnt, 255);
      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
